// File: rtl/uart_burst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_burst_pkg
//  Description : Shared definitions for the UART burst loop-back checker:
//                pattern mode encodings, checker state encoding, PRBS16 seed
//                and tap mask, and a single-step PRBS16 helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_burst_pkg;

    // Pattern select encodings (latched at start)
    localparam logic [1:0] MODE_INC   = 2'b00;
    localparam logic [1:0] MODE_DEC   = 2'b01;
    localparam logic [1:0] MODE_PRBS  = 2'b10;
    localparam logic [1:0] MODE_CONST = 2'b11;

    // Checker sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND   = 3'd1,
        ST_TXWAIT = 3'd2,
        ST_RXWAIT = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // PRBS16 x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form:
    // feedback is the XOR of register bits 0, 2, 3 and 5, entering at bit 15.
    localparam logic [15:0] PRBS_SEED = 16'hACE1;
    localparam logic [15:0] PRBS_TAPS = 16'h002D;

    function automatic logic [15:0] prbs_step(input logic [15:0] s);
        return {^(s & PRBS_TAPS), s[15:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/burst_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : burst_pattern_gen
//  Description : Word pattern source for the burst checker. One instance
//                serves both transmit and compare, since the checker compares
//                against the word it last sent.
//  Ports       : sys_clk, sys_rst_n   clock / async active-low reset
//                load                 latch mode and seed, restart pattern
//                advance              step to the next pattern word
//                mode [1:0]           pattern select (inc/dec/prbs/const)
//                seed [DATA_W-1:0]    pattern seed
//                word [DATA_W-1:0]    current pattern word
//  Revision    : 1.0  initial release
// ============================================================================
module burst_pattern_gen
    import uart_burst_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] word
);

    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_word;
    logic [15:0]       r_prbs;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode <= MODE_INC;
            r_word <= '0;
            r_prbs <= PRBS_SEED;
        end else if (load) begin
            r_mode <= mode;
            r_word <= seed;
            // OR-ing onto a non-zero constant keeps the LFSR out of the
            // all-zero lock-up state whatever the seed.
            r_prbs <= PRBS_SEED | {{(16-DATA_W){1'b0}}, seed};
        end else if (advance) begin
            case (r_mode)
                MODE_INC:  r_word <= r_word + 1'b1;
                MODE_DEC:  r_word <= r_word - 1'b1;
                MODE_PRBS: r_prbs <= prbs_step(r_prbs);
                default:   r_word <= r_word;
            endcase
        end
    end

    assign word = (r_mode == MODE_PRBS) ? r_prbs[DATA_W-1:0] : r_word;

endmodule
`default_nettype wire

// File: rtl/uart_burst_checker.sv
`default_nettype none
// ============================================================================
//  Module      : uart_burst_checker
//  Description : Sends a burst of BURST_LEN pattern words through the uart_tx
//                handshake and checks each loop-back word from uart_rx, with
//                a per-word receive timeout. Reports sent/received/error
//                counts and a pass flag at end of burst.
//  Ports       : sys_clk, sys_rst_n   clock / async active-low reset
//                start, mode, seed    burst request and pattern selection
//                tx_en, tx_data       send strobe and word to uart_tx
//                tx_busy              uart_tx busy flag
//                rx_done, rx_data     uart_rx word-valid strobe and word
//                busy, done, pass     burst status
//                sent_cnt, rcvd_cnt,
//                err_cnt              burst statistics (err_cnt saturates)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_burst_checker
    import uart_burst_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int UART_BPS     = 115200,
    parameter int DATA_W       = 8,
    parameter int BURST_LEN    = 256,
    parameter int TIMEOUT_BITS = 16,
    parameter int CNT_W        = $clog2(BURST_LEN + 1)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic              tx_en,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  sent_cnt,
    output logic [CNT_W-1:0]  rcvd_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int BPS_CNT      = CLK_FREQ / UART_BPS;
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * BPS_CNT;
    localparam int TMR_W        = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [CNT_W-1:0] c_burst_len    = CNT_W'(BURST_LEN);
    localparam logic [TMR_W-1:0] c_timeout_last = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [1:0]       c_txw_last     = 2'd3;

    state_t            r_state;
    logic [TMR_W-1:0]  r_timer;
    logic [1:0]        r_txw_cnt;
    logic              r_seen_busy;

    logic              w_gen_load;
    logic              w_gen_adv;
    logic [DATA_W-1:0] w_word;
    logic              w_timeout;
    logic              w_err_hit;

    assign w_gen_load = (r_state == ST_IDLE) && start;
    assign w_gen_adv  = (r_state == ST_NEXT);
    // Timer is cleared in SEND and counts from the tx_en cycle, so this
    // fires TIMEOUT_CLKS cycles after the strobe.
    assign w_timeout  = (r_timer >= c_timeout_last);

    burst_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (w_gen_load),
        .advance   (w_gen_adv),
        .mode      (mode),
        .seed      (seed),
        .word      (w_word)
    );

    // One error source per cycle at most: either the RXWAIT verdict
    // (mismatch, or timeout with no word) or a stray rx_done while the
    // checker is not expecting one. IDLE never counts.
    always_comb begin
        w_err_hit = 1'b0;
        case (r_state)
            ST_IDLE:   w_err_hit = 1'b0;
            ST_RXWAIT: w_err_hit = rx_done ? (rx_data != tx_data) : w_timeout;
            default:   w_err_hit = rx_done;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_txw_cnt   <= '0;
            r_seen_busy <= 1'b0;
            tx_en       <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            sent_cnt    <= '0;
            rcvd_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            tx_en <= 1'b0;
            done  <= 1'b0;

            if (w_err_hit && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    // busy drops the cycle after the done pulse
                    if (done) begin
                        busy <= 1'b0;
                    end
                    if (start) begin
                        busy     <= 1'b1;
                        pass     <= 1'b0;
                        sent_cnt <= '0;
                        rcvd_cnt <= '0;
                        err_cnt  <= '0;
                        r_state  <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    tx_en       <= 1'b1;
                    tx_data     <= w_word;
                    sent_cnt    <= sent_cnt + 1'b1;
                    r_timer     <= '0;
                    r_txw_cnt   <= '0;
                    r_seen_busy <= 1'b0;
                    r_state     <= ST_TXWAIT;
                end

                ST_TXWAIT: begin
                    if (!w_timeout) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    // A stuck-high tx_busy would otherwise hang the burst;
                    // the receive timer bounds it instead.
                    if (w_timeout) begin
                        r_state <= ST_RXWAIT;
                    end else if (tx_busy) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy || (r_txw_cnt == c_txw_last)) begin
                        r_state <= ST_RXWAIT;
                    end else begin
                        r_txw_cnt <= r_txw_cnt + 1'b1;
                    end
                end

                ST_RXWAIT: begin
                    if (!w_timeout) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    if (rx_done) begin
                        rcvd_cnt <= rcvd_cnt + 1'b1;
                        r_state  <= ST_NEXT;
                    end else if (w_timeout) begin
                        r_state <= ST_NEXT;
                    end
                end

                ST_NEXT: begin
                    r_state <= (sent_cnt == c_burst_len) ? ST_DONE : ST_SEND;
                end

                ST_DONE: begin
                    done    <= 1'b1;
                    pass    <= (err_cnt == '0);
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_burst_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_burst_checker
//  Description : Self-checking bench for uart_burst_checker with a behavioural
//                uart_tx/uart_rx loop-back model and an expected-word queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_burst_checker;

    localparam int CLK_FREQ     = 1000000;
    localparam int UART_BPS     = 100000;
    localparam int DATA_W       = 8;
    localparam int BURST_LEN    = 4;
    localparam int TIMEOUT_BITS = 16;
    localparam int BPS_CNT      = CLK_FREQ / UART_BPS;
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * BPS_CNT;
    localparam int CNT_W        = $clog2(BURST_LEN + 1);
    localparam int FRAME        = 10 * BPS_CNT;
    localparam int RX_LAT       = 3;
    localparam int BUDGET       = 4000;

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              start     = 1'b0;
    logic [1:0]        mode      = 2'b00;
    logic [DATA_W-1:0] seed      = '0;
    logic              tx_en;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy   = 1'b0;
    logic              rx_done   = 1'b0;
    logic [DATA_W-1:0] rx_data   = '0;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  sent_cnt;
    logic [CNT_W-1:0]  rcvd_cnt;
    logic [CNT_W-1:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    // Loop-back model controls (written by the test sequence only)
    bit loop_en     = 1'b1;
    int corrupt_idx = -1;
    int tb_epoch    = 0;
    int inject_cnt  = 0;

    // Loop-back model state (written by the model only)
    int                m_t     = 0;
    int                m_idx   = 0;
    int                m_epoch = 0;
    int                m_inj   = 0;
    logic [DATA_W-1:0] m_data  = '0;

    logic [DATA_W-1:0] exp_q[$];

    uart_burst_checker #(
        .CLK_FREQ     (CLK_FREQ),
        .UART_BPS     (UART_BPS),
        .DATA_W       (DATA_W),
        .BURST_LEN    (BURST_LEN),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .mode      (mode),
        .seed      (seed),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .sent_cnt  (sent_cnt),
        .rcvd_cnt  (rcvd_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // uart_tx/uart_rx pair: busy rises one cycle after tx_en for one frame,
    // the received word appears RX_LAT cycles after busy falls.
    always @(negedge sys_clk) begin
        rx_done = 1'b0;
        if (!sys_rst_n) begin
            m_t     = 0;
            tx_busy = 1'b0;
            m_inj   = inject_cnt;
        end else begin
            if (m_epoch != tb_epoch) begin
                m_epoch = tb_epoch;
                m_idx   = 0;
            end
            if (m_inj != inject_cnt) begin
                m_inj   = inject_cnt;
                rx_done = 1'b1;
                rx_data = 8'h3C;
            end
            if (tx_en) begin
                m_data = tx_data;
                m_t    = 1;
            end else if (m_t > 0) begin
                m_t++;
                tx_busy = (m_t >= 2) && (m_t < 2 + FRAME);
                if (m_t == 2 + FRAME + RX_LAT) begin
                    if (loop_en) begin
                        rx_done = 1'b1;
                        rx_data = (m_idx == corrupt_idx) ? (m_data ^ 8'h01) : m_data;
                    end
                    m_idx++;
                    m_t = 0;
                end
            end
        end
    end

    // Reference pattern: i-th word of a burst
    function automatic logic [DATA_W-1:0] exp_word(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] sd,
                                                   input int i);
        logic [15:0]       s;
        logic [DATA_W-1:0] w;
        logic              fb;
        s = 16'hACE1 | {8'h00, sd};
        w = sd;
        for (int k = 0; k < i; k++) begin
            fb = s[0] ^ s[2] ^ s[3] ^ s[5];
            s  = {fb, s[15:1]};
            if (m == 2'b00) w = w + 8'd1;
            if (m == 2'b01) w = w - 8'd1;
        end
        return (m == 2'b10) ? s[DATA_W-1:0] : w;
    endfunction

    // Runs one burst. inj_word: after that word's tx_en, pulse start and a
    // stray rx_done. rst_word: reset asserted at that word's tx_en.
    task automatic do_burst(input logic [1:0] m, input logic [DATA_W-1:0] sd,
                            input int inj_word, input int rst_word,
                            input int exp_rcvd, input int exp_err, input bit chk_gap);
        int n, widx, last_en, inj_phase;
        bit fin, rst_hit;
        logic [DATA_W-1:0] w;
        exp_q.delete();
        for (int i = 0; i < BURST_LEN; i++) exp_q.push_back(exp_word(m, sd, i));
        tb_epoch++;
        @(negedge sys_clk);
        mode = m; seed = sd; start = 1'b1;
        n = 0; widx = 0; last_en = -1; inj_phase = 0; fin = 1'b0; rst_hit = 1'b0;
        while (!fin && n < BUDGET) begin
            @(negedge sys_clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL busy_after_start: got %b expected 1", busy);
                end
            end
            if (inj_phase == 1) begin
                start = 1'b1; inject_cnt++; inj_phase = 2;
            end else if (inj_phase == 2) begin
                start = 1'b0; inj_phase = 3;
            end
            if (tx_en) begin
                if (widx == 0) begin
                    checks++;
                    if (n != 2) begin
                        errors++; $display("FAIL start_to_tx_en: got %0d cycles expected 2", n);
                    end
                end
                if (chk_gap && last_en >= 0) begin
                    checks++;
                    if (n - last_en < TIMEOUT_CLKS || n - last_en > TIMEOUT_CLKS + 4) begin
                        errors++;
                        $display("FAIL timeout_gap: got %0d cycles expected %0d..%0d",
                                 n - last_en, TIMEOUT_CLKS, TIMEOUT_CLKS + 4);
                    end
                end
                last_en = n;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL extra_word: got %h expected none", tx_data);
                end else begin
                    w = exp_q.pop_front();
                    if (tx_data !== w) begin
                        errors++; $display("FAIL tx_word%0d: got %h expected %h", widx, tx_data, w);
                    end
                end
                if (widx == inj_word) inj_phase = 1;
                if (widx == rst_word) begin
                    sys_rst_n = 1'b0;
                    #1;
                    checks++;
                    if ({tx_en, tx_data, busy, done, pass, sent_cnt, rcvd_cnt, err_cnt} !== '0) begin
                        errors++;
                        $display("FAIL mid_reset_outputs: got en=%b d=%h busy=%b done=%b pass=%b s=%0d r=%0d e=%0d expected all 0",
                                 tx_en, tx_data, busy, done, pass, sent_cnt, rcvd_cnt, err_cnt);
                    end
                    @(negedge sys_clk);
                    @(negedge sys_clk);
                    sys_rst_n = 1'b1;
                    fin = 1'b1; rst_hit = 1'b1;
                end
                widx++;
            end
            if (!fin && done) begin
                fin = 1'b1;
                checks++;
                if (sent_cnt !== CNT_W'(BURST_LEN) || rcvd_cnt !== CNT_W'(exp_rcvd) ||
                    err_cnt !== CNT_W'(exp_err) || pass !== (exp_err == 0) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL done_stats: got sent=%0d rcvd=%0d err=%0d pass=%b busy=%b expected %0d %0d %0d %b 1",
                             sent_cnt, rcvd_cnt, err_cnt, pass, busy,
                             BURST_LEN, exp_rcvd, exp_err, (exp_err == 0));
                end
                @(negedge sys_clk);
                checks++;
                if (done !== 1'b0 || busy !== 1'b0 || pass !== (exp_err == 0)) begin
                    errors++;
                    $display("FAIL after_done: got done=%b busy=%b pass=%b expected 0 0 %b",
                             done, busy, pass, (exp_err == 0));
                end
            end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL burst_timeout: got no done after %0d cycles expected done", n);
        end
        if (!rst_hit) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++; $display("FAIL missing_words: got %0d unsent expected 0", exp_q.size());
            end
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({tx_en, tx_data, busy, done, pass, sent_cnt, rcvd_cnt, err_cnt} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs expected all 0");
        end
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({tx_en, busy, done, pass, sent_cnt, rcvd_cnt, err_cnt} !== '0) begin
            errors++; $display("FAIL idle_outputs: got nonzero outputs expected all 0");
        end
    endtask

    task automatic test_inc_loopback();
        do_burst(2'b00, 8'hFE, -1, -1, BURST_LEN, 0, 1'b0);
    endtask

    task automatic test_prbs();
        do_burst(2'b10, 8'h12, -1, -1, BURST_LEN, 0, 1'b0);
    endtask

    task automatic test_corrupt();
        corrupt_idx = 1;
        do_burst(2'b00, 8'h10, -1, -1, BURST_LEN, 1, 1'b0);
        corrupt_idx = -1;
    endtask

    task automatic test_timeout();
        loop_en = 1'b0;
        do_burst(2'b01, 8'h00, -1, -1, 0, BURST_LEN, 1'b1);
        loop_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_burst(2'b01, 8'h05, -1, 1, 0, 0, 1'b0);
        do_burst(2'b01, 8'h05, -1, -1, BURST_LEN, 0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        do_burst(2'b11, 8'hA5, 0, -1, BURST_LEN, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_inc_loopback();
        test_prbs();
        test_corrupt();
        test_timeout();
        test_reset_mid();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
